jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
Generic IEEE 1149.1 TAP controller clocked by tck. It decodes tms into the 16-state TAP FSM and owns the instruction register plus the built-in BYPASS and IDCODE data registers. It sits directly upstream of jtag_gpios and drives ir, capture_dr, shift_dr and update_dr to it. All other DR shift data enters on tdo_i and is returned on tdo. This replaces the vendor TAP on boards that expose raw JTAG pins.

Parameters:
IR_BITS, 4, instruction register width; must equal `IR_LENGTH.
IDCODE_VALUE, 32'h1000_0001, value captured into the IDCODE DR; bit 0 must be 1.
IR_IDCODE, 4'b0010, opcode selecting IDCODE DR; loaded into ir in Test-Logic-Reset.
IR_BYPASS, 4'b1111, opcode selecting BYPASS DR; any opcode not decoded downstream also behaves as BYPASS only when equal to this value.

Ports:
tck  input  1  JTAG clock; the single clock of the block
trst  input  1  asynchronous active-high reset
tms  input  1  test mode select, sampled on rising tck
tdi  input  1  test data in, sampled on rising tck
tdo  output  1  test data out
tdo_ena  output  1  high while shifting IR or DR (pad output enable)
tdo_i  input  1  serial data from downstream DRs (jtag_gpios tdo mux)
ir  output  IR_BITS  current instruction
test_logic_reset  output  1  FSM in Test-Logic-Reset
capture_dr  output  1  FSM in Capture-DR
shift_dr  output  1  FSM in Shift-DR
update_dr  output  1  FSM in Update-DR
shift_ir  output  1  FSM in Shift-IR

Behaviour:
- Clock tck; reset trst is asynchronous and active-high. On trst: state=TLR, ir=IR_IDCODE, ir_sr=0, bypass_reg=0, idcode_sr=IDCODE_VALUE.
- State register is 4 bits with the standard 16 states. Transitions happen on rising tck per tms:
  - TLR: 1->TLR, 0->RTI. RTI: 1->SelDR, 0->RTI.
  - SelDR: 1->SelIR, 0->CapDR. SelIR: 1->TLR, 0->CapIR.
  - Cap*: 1->Exit1, 0->Shift. Shift: 1->Exit1, 0->Shift.
  - Exit1: 1->Update, 0->Pause. Pause: 1->Exit2, 0->Pause.
  - Exit2: 1->Update, 0->Shift. Update: 1->SelDR, 0->RTI.
- Five consecutive tms=1 edges reach TLR from any state.
- capture_dr, shift_dr, update_dr, shift_ir and test_logic_reset are pure decodes of the state register. Each is high for exactly the tck cycles spent in its state. Downstream acts on the rising edge while the strobe is high.
- IR path, all on rising tck:
  - CapIR: ir_sr <= {0..., 2'b01}.
  - ShiftIR: ir_sr <= {tdi, ir_sr[IR_BITS-1:1]}.
  - UpdateIR: ir <= ir_sr, so the new ir is visible one tck after entering UpdateIR.
  - TLR: ir <= IR_IDCODE every cycle.
- BYPASS DR: CapDR loads bypass_reg <= 0; ShiftDR loads bypass_reg <= tdi. This gives a one-cycle delay through the block.
- IDCODE DR: CapDR loads idcode_sr <= IDCODE_VALUE; ShiftDR does idcode_sr <= {tdi, idcode_sr[31:1]}. Output is LSB first.
- TDO source select:
  - ShiftIR: ir_sr[0].
  - ShiftDR with ir==IR_IDCODE: idcode_sr[0].
  - ShiftDR with ir==IR_BYPASS: bypass_reg.
  - ShiftDR, any other ir: tdo_i.
  - Not shifting: 0, with tdo_ena=0.
- Pause states hold all shift registers unchanged.
- trst asserted mid-shift aborts immediately: IR reverts to IR_IDCODE and downstream sees no update_dr pulse.

Optional Feature:
TAP_TDO_NEGEDGE_EN:
- Defined: tdo and tdo_ena are registered on falling tck from the select logic above, per IEEE 1149.1. Both reset to 0 on trst, and tdo lags the state by half a cycle.
- Undefined: tdo and tdo_ena are combinational from posedge flops. This is for FPGA-internal use where the host samples on the next rising edge.

Test Plan:
- Assert trst 2 cycles, release -> test_logic_reset=1, ir=4'b0010; tms 0 -> RTI.
- After reset, go to ShiftDR and shift 32 bits of tdi=0 -> tdo stream LSB-first equals 32'h1000_0001, tdo_ena=1 for all 32 shifts.
- IR scan shifting in 4'b1111 -> first 4 tdo bits = 1,0,0,0 (capture pattern 0001). ir=4'b1111 one tck after UpdateIR. DR shift of 1,0,1,1 -> tdo 0,1,0,1 (captured 0 then one-cycle delay).
- Load `SCAN_N, drive tdo_i=1,0,1 during 3 ShiftDR cycles -> tdo=1,0,1. capture_dr and update_dr each pulse exactly 1 cycle per scan.
- From ShiftDR, tms=1 for 5 edges -> TLR with ir=IR_IDCODE; one update_dr pulse occurs on the way (Exit1->Update). Compare with trst asserted mid-ShiftDR -> TLR immediately, no update_dr.
- With TAP_TDO_NEGEDGE_EN defined, repeat the IDCODE read -> same bit sequence, each bit changing on the falling tck edge.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register, and the
// built-in BYPASS and IDCODE data registers. Other DR data is taken from tdo_i.
// Optional macro TAP_TDO_NEGEDGE_EN: register tdo/tdo_ena on falling tck.
module jtag_tap_ctrl #(
    parameter int unsigned        IR_BITS      = 4,
    parameter logic [31:0]        IDCODE_VALUE = 32'h1000_0001,
    parameter logic [IR_BITS-1:0] IR_IDCODE    = 4'b0010,
    parameter logic [IR_BITS-1:0] IR_BYPASS    = 4'b1111
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               tms,
    input  logic               tdi,
    output logic               tdo,
    output logic               tdo_ena,
    input  logic               tdo_i,
    output logic [IR_BITS-1:0] ir,
    output logic               test_logic_reset,
    output logic               capture_dr,
    output logic               shift_dr,
    output logic               update_dr,
    output logic               shift_ir
);

    // Standard 1149.1 state encoding
    typedef enum logic [3:0] {
        StExit2Dr  = 4'h0,
        StExit1Dr  = 4'h1,
        StShiftDr  = 4'h2,
        StPauseDr  = 4'h3,
        StSelIr    = 4'h4,
        StUpdateDr = 4'h5,
        StCapDr    = 4'h6,
        StSelDr    = 4'h7,
        StExit2Ir  = 4'h8,
        StExit1Ir  = 4'h9,
        StShiftIr  = 4'hA,
        StPauseIr  = 4'hB,
        StRti      = 4'hC,
        StUpdateIr = 4'hD,
        StCapIr    = 4'hE,
        StTlr      = 4'hF
    } tap_state_e;

    tap_state_e         state_q, state_d;
    logic [IR_BITS-1:0] ir_q;
    logic [IR_BITS-1:0] ir_sr_q;
    logic               bypass_q;
    logic [31:0]        idcode_sr_q;
    logic               tdo_sel;
    logic               tdo_ena_sel;

    // State register
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= StTlr;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from tms
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:      state_d = tms ? StTlr      : StRti;
            StRti:      state_d = tms ? StSelDr    : StRti;
            StSelDr:    state_d = tms ? StSelIr    : StCapDr;
            StCapDr:    state_d = tms ? StExit1Dr  : StShiftDr;
            StShiftDr:  state_d = tms ? StExit1Dr  : StShiftDr;
            StExit1Dr:  state_d = tms ? StUpdateDr : StPauseDr;
            StPauseDr:  state_d = tms ? StExit2Dr  : StPauseDr;
            StExit2Dr:  state_d = tms ? StUpdateDr : StShiftDr;
            StUpdateDr: state_d = tms ? StSelDr    : StRti;
            StSelIr:    state_d = tms ? StTlr      : StCapIr;
            StCapIr:    state_d = tms ? StExit1Ir  : StShiftIr;
            StShiftIr:  state_d = tms ? StExit1Ir  : StShiftIr;
            StExit1Ir:  state_d = tms ? StUpdateIr : StPauseIr;
            StPauseIr:  state_d = tms ? StExit2Ir  : StPauseIr;
            StExit2Ir:  state_d = tms ? StUpdateIr : StShiftIr;
            StUpdateIr: state_d = tms ? StSelDr    : StRti;
            default:    state_d = StTlr;
        endcase
    end

    // State strobes are pure decodes of the state register
    always_comb begin
        test_logic_reset = (state_q == StTlr);
        capture_dr       = (state_q == StCapDr);
        shift_dr         = (state_q == StShiftDr);
        update_dr        = (state_q == StUpdateDr);
        shift_ir         = (state_q == StShiftIr);
    end

    // Instruction shift register and instruction latch
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_q    <= IR_IDCODE;
            ir_sr_q <= '0;
        end else begin
            unique case (state_q)
                StTlr:      ir_q    <= IR_IDCODE;
                StCapIr:    ir_sr_q <= {{(IR_BITS-1){1'b0}}, 1'b1};
                StShiftIr:  ir_sr_q <= {tdi, ir_sr_q[IR_BITS-1:1]};
                StUpdateIr: ir_q    <= ir_sr_q;
                default:    ;
            endcase
        end
    end

    // BYPASS and IDCODE data registers; pause states fall to default and hold
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            bypass_q    <= 1'b0;
            idcode_sr_q <= IDCODE_VALUE;
        end else begin
            unique case (state_q)
                StCapDr: begin
                    bypass_q    <= 1'b0;
                    idcode_sr_q <= IDCODE_VALUE;
                end
                StShiftDr: begin
                    bypass_q    <= tdi;
                    idcode_sr_q <= {tdi, idcode_sr_q[31:1]};
                end
                default: ;
            endcase
        end
    end

    // TDO source select
    always_comb begin
        tdo_sel     = 1'b0;
        tdo_ena_sel = 1'b0;
        if (state_q == StShiftIr) begin
            tdo_sel     = ir_sr_q[0];
            tdo_ena_sel = 1'b1;
        end else if (state_q == StShiftDr) begin
            tdo_ena_sel = 1'b1;
            if (ir_q == IR_IDCODE) begin
                tdo_sel = idcode_sr_q[0];
            end else if (ir_q == IR_BYPASS) begin
                tdo_sel = bypass_q;
            end else begin
                tdo_sel = tdo_i;
            end
        end
    end

`ifdef TAP_TDO_NEGEDGE_EN
    logic tdo_q;
    logic tdo_ena_q;

    // Launch tdo on falling tck so the host samples a stable bit on the rising edge
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo_q     <= 1'b0;
            tdo_ena_q <= 1'b0;
        end else begin
            tdo_q     <= tdo_sel;
            tdo_ena_q <= tdo_ena_sel;
        end
    end

    assign tdo     = tdo_q;
    assign tdo_ena = tdo_ena_q;
`else
    assign tdo     = tdo_sel;
    assign tdo_ena = tdo_ena_sel;
`endif

    assign ir = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: table-driven FSM/IR/BYPASS walk plus
// hand-written IDCODE read, tdo_i passthrough, 5x tms reset and trst abort.
module tb_jtag_tap_ctrl;

    logic       tck = 1'b0;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_ena;
    logic       tdo_i;
    logic [3:0] ir;
    logic       test_logic_reset;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       shift_ir;

    int n_cmp = 0;
    int n_err = 0;
    int cap_cnt = 0;
    int upd_cnt = 0;

    jtag_tap_ctrl dut (
        .tck              (tck),
        .trst             (trst),
        .tms              (tms),
        .tdi              (tdi),
        .tdo              (tdo),
        .tdo_ena          (tdo_ena),
        .tdo_i            (tdo_i),
        .ir               (ir),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .shift_ir         (shift_ir)
    );

    always #5 tck = ~tck;

    // Count strobe cycles as seen by a downstream posedge consumer
    always @(posedge tck) begin
        if (capture_dr) cap_cnt++;
        if (update_dr) upd_cnt++;
    end

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [4:0] flags;  // {tlr, cap_dr, shift_dr, upd_dr, shift_ir}
        logic       tdo;
        logic       ena;
        logic [3:0] ir;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vec [NVEC];

    function automatic vec_t mk(input logic m, input logic d, input logic [4:0] f,
                                input logic o, input logic e, input logic [3:0] r);
        vec_t v;
        v.tms = m; v.tdi = d; v.flags = f; v.tdo = o; v.ena = e; v.ir = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, settle past the falling edge
    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #8;
    endtask

    // From RTI: scan an opcode into IR and return to RTI
    task automatic load_ir(input logic [3:0] op);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From RTI into Shift-DR
    task automatic go_shift_dr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic        ena_all;
        logic [2:0]  pt;
        logic [10:0] act;
        logic [10:0] exp;

        // IR scan to BYPASS, bypass shift with pause, then 5x tms=1 to TLR
        vec[0]  = mk(0, 0, 5'b00000, 0, 0, 4'b0010);  // RTI
        vec[1]  = mk(1, 0, 5'b00000, 0, 0, 4'b0010);  // SelDR
        vec[2]  = mk(1, 0, 5'b00000, 0, 0, 4'b0010);  // SelIR
        vec[3]  = mk(0, 0, 5'b00000, 0, 0, 4'b0010);  // CapIR
        vec[4]  = mk(0, 0, 5'b00001, 1, 1, 4'b0010);  // ShiftIR, capture bit 1
        vec[5]  = mk(0, 1, 5'b00001, 0, 1, 4'b0010);
        vec[6]  = mk(0, 1, 5'b00001, 0, 1, 4'b0010);
        vec[7]  = mk(0, 1, 5'b00001, 0, 1, 4'b0010);
        vec[8]  = mk(1, 1, 5'b00000, 0, 0, 4'b0010);  // Exit1IR
        vec[9]  = mk(1, 0, 5'b00000, 0, 0, 4'b0010);  // UpdateIR, ir not yet changed
        vec[10] = mk(0, 0, 5'b00000, 0, 0, 4'b1111);  // RTI, ir = BYPASS
        vec[11] = mk(1, 0, 5'b00000, 0, 0, 4'b1111);  // SelDR
        vec[12] = mk(0, 0, 5'b01000, 0, 0, 4'b1111);  // CapDR
        vec[13] = mk(0, 0, 5'b00100, 0, 1, 4'b1111);  // ShiftDR, captured 0
        vec[14] = mk(0, 1, 5'b00100, 1, 1, 4'b1111);
        vec[15] = mk(0, 0, 5'b00100, 0, 1, 4'b1111);
        vec[16] = mk(0, 1, 5'b00100, 1, 1, 4'b1111);
        vec[17] = mk(1, 1, 5'b00000, 0, 0, 4'b1111);  // Exit1DR
        vec[18] = mk(0, 0, 5'b00000, 0, 0, 4'b1111);  // PauseDR
        vec[19] = mk(0, 0, 5'b00000, 0, 0, 4'b1111);  // PauseDR
        vec[20] = mk(1, 0, 5'b00000, 0, 0, 4'b1111);  // Exit2DR
        vec[21] = mk(0, 0, 5'b00100, 1, 1, 4'b1111);  // ShiftDR, bypass held 1
        vec[22] = mk(1, 0, 5'b00000, 0, 0, 4'b1111);  // Exit1DR
        vec[23] = mk(1, 0, 5'b00010, 0, 0, 4'b1111);  // UpdateDR
        vec[24] = mk(1, 0, 5'b00000, 0, 0, 4'b1111);  // SelDR
        vec[25] = mk(1, 0, 5'b00000, 0, 0, 4'b1111);  // SelIR
        vec[26] = mk(1, 0, 5'b10000, 0, 0, 4'b1111);  // TLR entered, ir reloads next edge
        vec[27] = mk(1, 0, 5'b10000, 0, 0, 4'b0010);  // TLR, ir = IDCODE
        vec[28] = mk(0, 0, 5'b00000, 0, 0, 4'b0010);  // RTI

        // Reset
        trst = 1'b1; tms = 1'b1; tdi = 1'b0; tdo_i = 1'b0;
        repeat (2) @(posedge tck);
        #8;
        trst = 1'b0;
        check("reset_tlr", test_logic_reset, 1);
        check("reset_ir", ir, 4'b0010);
        check("reset_tdo_ena", tdo_ena, 0);
        tick(1'b0, 1'b0);
        check("rti_tlr_low", test_logic_reset, 0);

        // IDCODE read after reset
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tms = 1'b0;
        @(posedge tck);
        #1;
`ifdef TAP_TDO_NEGEDGE_EN
        check("ena_before_negedge", tdo_ena, 0);
`else
        check("ena_before_negedge", tdo_ena, 1);
`endif
        #7;
        got = '0;
        ena_all = 1'b1;
        for (int i = 0; i < 32; i++) begin
            got[i] = tdo;
            ena_all = ena_all & tdo_ena;
            tick(i == 31, 1'b0);
        end
        check("idcode_stream", got, 32'h1000_0001);
        check("idcode_ena", ena_all, 1);
        check("idcode_exit_ena", tdo_ena, 0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // Table walk
        for (int i = 0; i < NVEC; i++) begin
            tick(vec[i].tms, vec[i].tdi);
            act = {test_logic_reset, capture_dr, shift_dr, update_dr, shift_ir,
                   tdo, tdo_ena, ir};
            exp = {vec[i].flags, vec[i].tdo, vec[i].ena, vec[i].ir};
            check($sformatf("vec%0d", i), act, exp);
        end

        // Other opcode: tdo follows tdo_i, one capture and one update per scan
        load_ir(4'b0011);
        check("ir_other", ir, 4'b0011);
        cap_cnt = 0;
        upd_cnt = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tdo_i = 1'b1;
        tick(1'b0, 1'b0);
        pt[0] = tdo;
        tdo_i = 1'b0;
        tick(1'b0, 1'b0);
        pt[1] = tdo;
        tdo_i = 1'b1;
        tick(1'b0, 1'b0);
        pt[2] = tdo;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("tdo_i_pass", pt, 3'b101);
        check("cap_pulses", cap_cnt, 1);
        check("upd_pulses", upd_cnt, 1);

        // Five tms=1 edges from Shift-DR reach TLR with one update on the way
        go_shift_dr();
        upd_cnt = 0;
        repeat (5) tick(1'b1, 1'b0);
        check("tms5_tlr", test_logic_reset, 1);
        check("tms5_upd", upd_cnt, 1);
        tick(1'b1, 1'b0);
        check("tms5_ir", ir, 4'b0010);
        tick(1'b0, 1'b0);

        // trst mid Shift-DR aborts immediately, no update strobe
        load_ir(4'b0011);
        go_shift_dr();
        tick(1'b0, 1'b1);
        check("pre_abort_shift", shift_dr, 1);
        upd_cnt = 0;
        trst = 1'b1;
        #1;
        check("abort_tlr", test_logic_reset, 1);
        check("abort_ir", ir, 4'b0010);
        check("abort_ena", tdo_ena, 0);
        @(posedge tck);
        #8;
        trst = 1'b0;
        repeat (3) tick(1'b1, 1'b0);
        check("abort_no_upd", upd_cnt, 0);
        check("abort_stays_tlr", test_logic_reset, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
